// File: rtl/cblock_cfg_loader.sv
// Bit-serial configuration loader for the connection-block tile array: receives
// address/payload/parity frames and drives a shared payload bus plus one-hot tile write strobes.
module cblock_cfg_loader #(
  parameter int N_TILES = 16,
  parameter int ADDR_W  = 4,
  parameter int BITS_W  = 18,
  parameter int WR_CYC  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               cfg_valid,
  input  logic               cfg_data,
  output logic               cfg_ready,
  output logic [BITS_W-1:0]  cfg_bits,
  output logic [N_TILES-1:0] wr_en,
  output logic               busy,
  output logic               frame_done,
  output logic               err,
  output logic [7:0]         ok_cnt,
  // 0 IDLE, 1 ADDR, 2 DATA, 3 PAR, 4 SETUP, 5 WRITE, 6 HOLD
  output logic [2:0]         dbg_state
);

  // Handshake: one serial bit moves on every rising clk edge where cfg_valid && cfg_ready.
  // cfg_ready is decoded from state only (ADDR/DATA/PAR) and never looks at cfg_valid;
  // the source may hold cfg_valid low for any number of cycles without losing bits.

  localparam int MAX_A = (ADDR_W > BITS_W) ? ADDR_W : BITS_W;
  localparam int MAX_N = (MAX_A > WR_CYC) ? MAX_A : WR_CYC;
  localparam int CNT_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;

  localparam logic [CNT_W-1:0]   ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0]   DATA_LAST = CNT_W'(BITS_W - 1);
  localparam logic [CNT_W-1:0]   WR_LAST   = CNT_W'(WR_CYC - 1);
  localparam logic [ADDR_W:0]    TILE_LIM  = (ADDR_W + 1)'(N_TILES);
  localparam logic [N_TILES-1:0] TILE_ONE  = N_TILES'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_SETUP = 3'd4,
    S_WRITE = 3'd5,
    S_HOLD  = 3'd6
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    bit_cnt;
  logic [ADDR_W-1:0]   addr_sr;
  logic [BITS_W-1:0]   data_sr;
  logic                par_ok;
  logic                addr_ok;

  assign cfg_ready = (state == S_ADDR) || (state == S_DATA) || (state == S_PAR);
  assign dbg_state = state;

  // Even parity over address, payload and the incoming parity bit.
  assign par_ok  = ~^{addr_sr, data_sr, cfg_data};
  assign addr_ok = ({1'b0, addr_sr} < TILE_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      addr_sr    <= '0;
      data_sr    <= '0;
      cfg_bits   <= '0;
      wr_en      <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      ok_cnt     <= 8'd0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (en) begin
            state   <= S_ADDR;
            busy    <= 1'b1;
            err     <= 1'b0;
            bit_cnt <= '0;
            addr_sr <= '0;
            data_sr <= '0;
          end
        end
        S_ADDR: begin
          if (cfg_valid) begin
            addr_sr <= ADDR_W'({addr_sr, cfg_data});
            if (bit_cnt == ADDR_LAST) begin
              bit_cnt <= '0;
              state   <= S_DATA;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (cfg_valid) begin
            data_sr <= BITS_W'({data_sr, cfg_data});
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= S_PAR;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        S_PAR: begin
          if (cfg_valid) begin
            bit_cnt <= '0;
            if (par_ok && addr_ok) begin
              // The only edge on which the shared bus changes.
              cfg_bits <= data_sr;
              state    <= S_SETUP;
            end else begin
              err   <= 1'b1;
              state <= S_ADDR;
            end
          end
        end
        S_SETUP: begin
          wr_en   <= TILE_ONE << addr_sr;
          bit_cnt <= '0;
          state   <= S_WRITE;
        end
        S_WRITE: begin
          if (bit_cnt == WR_LAST) begin
            wr_en      <= '0;
            bit_cnt    <= '0;
            frame_done <= 1'b1;
            if (ok_cnt != 8'hFF) ok_cnt <= ok_cnt + 8'd1;
            state      <= S_HOLD;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          bit_cnt <= '0;
          if (en) begin
            state <= S_ADDR;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          wr_en <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  a_wr_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(wr_en));

endmodule

// File: tb/tb_cblock_cfg_loader.sv
// Directed bench for cblock_cfg_loader: a frame-level model predicts every output each
// cycle, and literal checks pin the key frames; a second instance covers N_TILES=12.
module tb_cblock_cfg_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        cfg_valid;
  logic        cfg_data;

  logic        cfg_ready;
  logic [17:0] cfg_bits;
  logic [15:0] wr_en;
  logic        busy, frame_done, err;
  logic [7:0]  ok_cnt;
  logic [2:0]  dbg_state;

  logic        cfg_ready12;
  logic [17:0] cfg_bits12;
  logic [11:0] wr_en12;
  logic        busy12, frame_done12, err12;
  logic [7:0]  ok_cnt12;
  logic [2:0]  dbg_state12;

  int n_vec  = 0;
  int n_fail = 0;
  int pulses = 0;
  bit flag12 = 1'b0;

  always #5 clk = ~clk;

  cblock_cfg_loader dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .cfg_bits(cfg_bits), .wr_en(wr_en), .busy(busy),
    .frame_done(frame_done), .err(err), .ok_cnt(ok_cnt), .dbg_state(dbg_state)
  );

  cblock_cfg_loader #(.N_TILES(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready12), .cfg_bits(cfg_bits12), .wr_en(wr_en12), .busy(busy12),
    .frame_done(frame_done12), .err(err12), .ok_cnt(ok_cnt12), .dbg_state(dbg_state12)
  );

  // ---------------- frame-level model of the 16-tile instance ----------------
  localparam int N_MODEL  = 16;
  localparam int WR_MODEL = 2;

  typedef struct packed {
    logic [15:0] wr;
    logic        done;
    logic        last;
  } step_t;

  step_t       sched[$];
  step_t       rec;
  int          m_phase;   // 0 idle, 1 receiving bits, 2 playing out a write
  int          m_nbits;
  logic [22:0] m_frame;
  logic [17:0] m_cfg;
  logic [15:0] m_wr;
  logic        m_done, m_err;
  logic [7:0]  m_ok;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_phase = 0; m_nbits = 0; m_frame = '0; m_cfg = '0; m_wr = '0;
        m_done = 1'b0; m_err = 1'b0; m_ok = 8'd0;
        sched.delete();
      end else begin
        m_done = 1'b0;
        if (m_phase == 0) begin
          if (en) begin
            m_phase = 1; m_err = 1'b0; m_nbits = 0;
          end
        end else if (m_phase == 1) begin
          if (cfg_valid) begin
            m_frame = {m_frame[21:0], cfg_data};
            m_nbits++;
            if (m_nbits == 23) begin
              m_nbits = 0;
              if ((^m_frame) == 1'b0 && int'(m_frame[22:19]) < N_MODEL) begin
                m_cfg   = m_frame[18:1];
                m_phase = 2;
                for (int k = 0; k < WR_MODEL; k++)
                  sched.push_back('{wr: 16'(1) << m_frame[22:19], done: 1'b0, last: 1'b0});
                sched.push_back('{wr: 16'h0, done: 1'b1, last: 1'b0});
                sched.push_back('{wr: 16'h0, done: 1'b0, last: 1'b1});
              end else begin
                m_err = 1'b1;
              end
            end
          end
        end else begin
          rec    = sched.pop_front();
          m_wr   = rec.wr;
          m_done = rec.done;
          if (rec.done && m_ok != 8'hFF) m_ok = m_ok + 8'd1;
          if (rec.last) m_phase = en ? 1 : 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  logic [17:0] prev_cfg = '0;
  logic [15:0] prev_wr  = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("cfg_ready",  cfg_ready,  m_phase == 1);
        chk("busy",       busy,       m_phase != 0);
        chk("cfg_bits",   cfg_bits,   m_cfg);
        chk("wr_en",      wr_en,      m_wr);
        chk("frame_done", frame_done, m_done);
        chk("err",        err,        m_err);
        chk("ok_cnt",     ok_cnt,     m_ok);
        if (cfg_bits !== prev_cfg) chk("bus_change_quiet", wr_en | prev_wr, 32'h0);
        if (wr_en != 16'h0 && prev_wr == 16'h0) pulses++;
        if (wr_en12 != 12'h0) flag12 = 1'b1;
      end
      prev_cfg = cfg_bits;
      prev_wr  = wr_en;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic par_of(input logic [3:0] a, input logic [17:0] d);
    return ^{a, d};
  endfunction

  task automatic send_frame(input logic [3:0] a, input logic [17:0] d, input logic p, input bit gaps);
    logic [22:0] w;
    int t;
    w = {a, d, p};
    for (int i = 22; i >= 0; i--) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        cfg_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          cfg_data = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
      end
      cfg_valid = 1'b1;
      cfg_data  = w[i];
      t = 0;
      while (!cfg_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (!cfg_ready) begin
        n_vec++;
        n_fail++;
        $display("FAIL ready_timeout: got cfg_ready 0 expected 1 within 100 cycles at %0t", $time);
      end
      @(negedge clk);
    end
    cfg_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!frame_done && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", frame_done, 1);
  endtask

  // ---------------- directed sequence ----------------
  int p0;
  logic [3:0]  ra;
  logic [17:0] rd;

  initial begin
    rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_data = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_cfg_bits", cfg_bits, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cfg_ready, 0);
    chk("rst_ok", ok_cnt, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_state", dbg_state, 3'd0);
    chk("idle_busy", busy, 0);

    // Good frame: addr 2 (1 one) + 18'h15A5C (9 ones) -> parity 0.
    en = 1'b1;
    send_frame(4'h2, 18'h15A5C, 1'b0, 1'b0);
    chk("setup_cfg", cfg_bits, 18'h15A5C);
    chk("setup_wr", wr_en, 16'h0000);
    @(negedge clk);
    chk("write1_wr", wr_en, 16'h0004);
    @(negedge clk);
    chk("write2_wr", wr_en, 16'h0004);
    @(negedge clk);
    chk("hold_wr", wr_en, 16'h0000);
    chk("hold_done", frame_done, 1);
    chk("hold_ok", ok_cnt, 8'd1);
    chk("hold_err", err, 0);
    chk("hold_cfg", cfg_bits, 18'h15A5C);

    // Same frame with wrong parity.
    send_frame(4'h2, 18'h15A5C, 1'b1, 1'b0);
    chk("perr_err", err, 1);
    chk("perr_state", dbg_state, 3'd1);
    chk("perr_ready", cfg_ready, 1);
    chk("perr_wr", wr_en, 16'h0000);
    chk("perr_ok", ok_cnt, 8'd1);
    send_frame(4'h7, 18'h00001, 1'b0, 1'b0);
    wait_done();
    chk("after_perr_ok", ok_cnt, 8'd2);
    chk("after_perr_err", err, 1);

    // Gappy source to the top tile.
    p0 = pulses;
    send_frame(4'hF, 18'h3FFFF, 1'b0, 1'b1);
    wait_done();
    chk("gap_cfg", cfg_bits, 18'h3FFFF);
    chk("gap_ok", ok_cnt, 8'd3);
    @(negedge clk);
    chk("gap_pulses", pulses - p0, 1);

    // en dropped before the frame: frame still completes, then IDLE.
    en = 1'b0;
    send_frame(4'h9, 18'h2AAAA, par_of(4'h9, 18'h2AAAA), 1'b0);
    wait_done();
    @(negedge clk);
    chk("en_low_state", dbg_state, 3'd0);
    chk("en_low_busy", busy, 0);
    chk("en_low_ok", ok_cnt, 8'd4);

    // Reset in the middle of WRITE.
    en = 1'b1;
    send_frame(4'h5, 18'h0F0F0, par_of(4'h5, 18'h0F0F0), 1'b0);
    @(negedge clk);
    chk("pre_rst_wr", wr_en, 16'h0020);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_wr", wr_en, 0);
    chk("async_rst_cfg", cfg_bits, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_ok", ok_cnt, 0);
    chk("async_rst_ready", cfg_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Address 12 is out of range for the 12-tile instance only.
    flag12 = 1'b0;
    send_frame(4'hC, 18'h00000, 1'b0, 1'b0);
    chk("oor_err12", err12, 1);
    chk("oor_state12", dbg_state12, 3'd1);
    chk("oor_ready12", cfg_ready12, 1);
    chk("oor_busy12", busy12, 1);
    chk("oor_cfg12", cfg_bits12, 0);
    chk("oor_done12", frame_done12, 0);
    wait_done();
    chk("oor_ok12", ok_cnt12, 0);
    chk("oor_wr12_quiet", flag12, 0);
    chk("oor_ok16", ok_cnt, 8'd1);

    // 260 back-to-back good frames: counter saturates.
    p0 = pulses;
    for (int n = 0; n < 260; n++) begin
      ra = 4'($urandom_range(0, 15));
      rd = 18'($urandom_range(0, 18'h3FFFF));
      send_frame(ra, rd, par_of(ra, rd), 1'b0);
    end
    wait_done();
    chk("sat_ok", ok_cnt, 8'd255);
    @(negedge clk);
    chk("b2b_pulses", pulses - p0, 260);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
